// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the dmem responder: request/response payloads,
// I/O window default and FSM state encodings.
package dmem_responder_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NBYTES = XLEN / 8;

   localparam logic [3:0] IO_PREFIX_DEFAULT = 4'hB;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_IO_WAIT = 2'd1;
   localparam logic [1:0] ST_IO_DONE = 2'd2;

   // Byte lanes are big-endian: wbe[3]/wd[31:24] is byte offset 0.
   typedef struct packed {
      logic [XLEN-1:0]   a;
      logic              r;
      logic              w;
      logic [XLEN-1:0]   wd;
      logic [NBYTES-1:0] wbe;
   } dmem_req_t;

   typedef struct packed {
      logic [XLEN-1:0] rd;
      logic            hold;
   } dmem_res_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data port plus the handshaked peripheral bus serviced by the responder.
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   dmem_req_t   req;
   dmem_res_t   res;
   logic [31:0] io_addr;
   logic        io_rd;
   logic        io_wr;
   logic [31:0] io_wdata;
   logic [3:0]  io_be;
   logic [31:0] io_rdata;
   logic        io_ack;
   logic        io_timeout;

   // Pipeline and peripheral side
   modport master (
      output req, io_rdata, io_ack,
      input  res, io_addr, io_rd, io_wr, io_wdata, io_be, io_timeout
   );

   modport slave (
      input  req, io_rdata, io_ack,
      output res, io_addr, io_rd, io_wr, io_wdata, io_be, io_timeout
   );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with four byte-wide write lanes and one-cycle synchronous read.
module dmem_ram #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              re_i,
   input  logic [3:0]        we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   // Read data holds when not enabled so a stalled read stays visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder: services RAM accesses locally and forwards I/O-window
// accesses to the peripheral bus, stalling the pipeline while one is outstanding.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W       = 12,
   parameter logic [3:0]  IO_PREFIX    = IO_PREFIX_DEFAULT,
   parameter int unsigned IO_TIMEOUT   = 255,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int unsigned CNT_W = 8;

   logic [1:0]       state_q, state_d;
   logic [31:0]      io_addr_q, io_addr_d;
   logic [31:0]      io_wdata_q, io_wdata_d;
   logic [3:0]       io_be_q, io_be_d;
   logic             io_rd_q, io_rd_d;
   logic             io_wr_q, io_wr_d;
   logic             io_timeout_q, io_timeout_d;
   logic [31:0]      rd_q, rd_d;
   logic             ram_sel_q, ram_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        hold_c, accept_c, io_sel_c, wr_c, ram_rd_c;
   logic [3:0]  ram_we_c;
   logic [31:0] ram_rdata;
   logic        unused_c;

   // Requests are only taken when not stalled; R and W together count as a write.
   assign hold_c   = (state_q == ST_IO_WAIT);
   assign accept_c = (bus.req.r | bus.req.w) & ~hold_c;
   assign io_sel_c = (bus.req.a[31:28] == IO_PREFIX);
   assign wr_c     = bus.req.w;
   assign ram_rd_c = accept_c & ~io_sel_c & ~wr_c;
   assign ram_we_c = (accept_c & ~io_sel_c & wr_c) ? bus.req.wbe : 4'b0000;
   assign unused_c = ^bus.req.a[1:0];

   dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk    (clk),
      .re_i   (ram_rd_c),
      .we_i   (ram_we_c),
      .addr_i (bus.req.a[ADDR_W+1:2]),
      .wdata_i(bus.req.wd),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      io_addr_d    = io_addr_q;
      io_wdata_d   = io_wdata_q;
      io_be_d      = io_be_q;
      io_rd_d      = io_rd_q;
      io_wr_d      = io_wr_q;
      rd_d         = rd_q;
      ram_sel_d    = ram_sel_q;
      cnt_d        = cnt_q;
      io_timeout_d = 1'b0;
      case (state_q)
         ST_IO_WAIT: begin
            // An ack in the final wait cycle beats the timeout.
            if (bus.io_ack) begin
               io_rd_d = 1'b0;
               io_wr_d = 1'b0;
               if (io_rd_q) rd_d = bus.io_rdata;
               state_d = ST_IO_DONE;
            end else if (cnt_q + CNT_W'(1) == CNT_W'(IO_TIMEOUT)) begin
               io_rd_d      = 1'b0;
               io_wr_d      = 1'b0;
               if (io_rd_q) rd_d = TIMEOUT_DATA;
               io_timeout_d = 1'b1;
               state_d      = ST_IO_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept_c) begin
               ram_sel_d = ram_rd_c;
               if (io_sel_c) begin
                  io_addr_d  = {bus.req.a[31:2], 2'b00};
                  io_wdata_d = bus.req.wd;
                  io_be_d    = wr_c ? bus.req.wbe : 4'hF;
                  io_rd_d    = ~wr_c;
                  io_wr_d    = wr_c;
                  cnt_d      = '0;
                  state_d    = ST_IO_WAIT;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         io_addr_q    <= '0;
         io_wdata_q   <= '0;
         io_be_q      <= '0;
         io_rd_q      <= 1'b0;
         io_wr_q      <= 1'b0;
         io_timeout_q <= 1'b0;
         rd_q         <= '0;
         ram_sel_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         io_addr_q    <= io_addr_d;
         io_wdata_q   <= io_wdata_d;
         io_be_q      <= io_be_d;
         io_rd_q      <= io_rd_d;
         io_wr_q      <= io_wr_d;
         io_timeout_q <= io_timeout_d;
         rd_q         <= rd_d;
         ram_sel_q    <= ram_sel_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.res        = {(ram_sel_q ? ram_rdata : rd_q), hold_c};
   assign bus.io_addr    = io_addr_q;
   assign bus.io_wdata   = io_wdata_q;
   assign bus.io_be      = io_be_q;
   assign bus.io_rd      = io_rd_q;
   assign bus.io_wr      = io_wr_q;
   assign bus.io_timeout = io_timeout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: word-level memory model plus transaction-level
// expectations for peripheral accesses (stall length, timeout, returned data).
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int          TMO      = 255;
   localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;
   logic [31:0] mem_m [int];

   dmem_responder_if bus();

   dmem_responder dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic dmem_req_t mkreq(input logic [31:0] a, input logic r, input logic w,
                                       input logic [31:0] wd, input logic [3:0] be);
      dmem_req_t q;
      q.a = a; q.r = r; q.w = w; q.wd = wd; q.wbe = be;
      return q;
   endfunction

   // Byte-lane merge of a store into a word: lane i covers bits [8i+7:8i].
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] v;
      v = old;
      for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One RAM access; RD is checked in the following cycle against the model.
   task automatic ram_op(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] wd, input logic [3:0] be);
      int          idx;
      logic [31:0] exp_v;
      idx   = int'(a[13:2]);
      exp_v = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      bus.req = mkreq(a, r, w, wd, be);
      step();
      bus.req = '0;
      nvec++;
      if (bus.res.hold !== 1'b0) begin nerr++; $display("FAIL ram_hold a=%h: got %b want 0", a, bus.res.hold); end
      if (w) mem_m[idx] = merge(exp_v, wd, be);
      else if (r) begin
         nvec++;
         if (bus.res.rd !== exp_v) begin nerr++; $display("FAIL ram_rd a=%h: got %h want %h", a, bus.res.rd, exp_v); end
      end
   endtask

   // One peripheral access; ack_dly is the wait-cycle index of the ack (<0: never).
   // Returns in the cycle HOLD drops, with hold_req presented.
   task automatic io_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input logic [3:0] be, input int ack_dly, input logic [31:0] rdata,
                         input dmem_req_t hold_req);
      int hcnt;
      bit to_exp;
      int h_exp;
      to_exp = !(ack_dly >= 0 && ack_dly < TMO);
      h_exp  = to_exp ? TMO : ack_dly + 1;
      bus.req = mkreq(a, !wr, wr, wd, be);
      step();
      bus.req = hold_req;
      nvec++;
      if (bus.io_addr !== {a[31:2], 2'b00}) begin nerr++; $display("FAIL io_addr: got %h want %h", bus.io_addr, {a[31:2], 2'b00}); end
      nvec++;
      if (bus.io_be !== (wr ? be : 4'hF)) begin nerr++; $display("FAIL io_be: got %h want %h", bus.io_be, (wr ? be : 4'hF)); end
      if (wr) begin
         nvec++;
         if (bus.io_wdata !== wd) begin nerr++; $display("FAIL io_wdata: got %h want %h", bus.io_wdata, wd); end
      end
      hcnt = 0;
      while (bus.res.hold === 1'b1 && hcnt < 400) begin
         nvec++;
         if (bus.io_rd !== logic'(!wr) || bus.io_wr !== logic'(wr)) begin
            nerr++; $display("FAIL io_strobe cyc=%0d: got rd=%b wr=%b want rd=%b wr=%b", hcnt, bus.io_rd, bus.io_wr, !wr, wr);
         end
         if (hcnt == ack_dly) begin bus.io_ack = 1'b1; bus.io_rdata = rdata; end
         step();
         bus.io_ack   = 1'b0;
         bus.io_rdata = $urandom;
         hcnt++;
      end
      nvec++;
      if (hcnt != h_exp) begin nerr++; $display("FAIL hold_cycles a=%h: got %0d want %0d", a, hcnt, h_exp); end
      nvec++;
      if ({bus.io_rd, bus.io_wr} !== 2'b00) begin nerr++; $display("FAIL io_strobe_drop: got %b want 00", {bus.io_rd, bus.io_wr}); end
      nvec++;
      if (bus.io_timeout !== logic'(to_exp)) begin nerr++; $display("FAIL io_timeout: got %b want %b", bus.io_timeout, to_exp); end
      if (!wr) begin
         nvec++;
         if (bus.res.rd !== (to_exp ? TMO_DATA : rdata)) begin
            nerr++; $display("FAIL io_rd_data: got %h want %h", bus.res.rd, (to_exp ? TMO_DATA : rdata));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.io_ack = 1'b0;
      bus.io_rdata = '0;
      #12;
      nvec++; if (bus.res.hold !== 1'b0)   begin nerr++; $display("FAIL rst_hold: got %b want 0", bus.res.hold); end
      nvec++; if (bus.res.rd !== 32'h0)     begin nerr++; $display("FAIL rst_rd: got %h want 0", bus.res.rd); end
      nvec++; if (bus.io_rd !== 1'b0)       begin nerr++; $display("FAIL rst_io_rd: got %b want 0", bus.io_rd); end
      nvec++; if (bus.io_wr !== 1'b0)       begin nerr++; $display("FAIL rst_io_wr: got %b want 0", bus.io_wr); end
      nvec++; if (bus.io_addr !== 32'h0)    begin nerr++; $display("FAIL rst_io_addr: got %h want 0", bus.io_addr); end
      nvec++; if (bus.io_wdata !== 32'h0)   begin nerr++; $display("FAIL rst_io_wdata: got %h want 0", bus.io_wdata); end
      nvec++; if (bus.io_be !== 4'h0)       begin nerr++; $display("FAIL rst_io_be: got %h want 0", bus.io_be); end
      nvec++; if (bus.io_timeout !== 1'b0)  begin nerr++; $display("FAIL rst_io_timeout: got %b want 0", bus.io_timeout); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_store_load();
      ram_op(32'h40, 1'b0, 1'b1, 32'h11223344, 4'hF);
      ram_op(32'h40, 1'b1, 1'b0, 32'h0, 4'h0);
      nvec++;
      if (bus.res.rd !== 32'h11223344) begin nerr++; $display("FAIL store_load: got %h want 11223344", bus.res.rd); end
   endtask

   task automatic test_byte_store();
      ram_op(32'h40, 1'b0, 1'b1, 32'hAABBCCDD, 4'hF);
      ram_op(32'h41, 1'b0, 1'b1, 32'h55555555, 4'h4);
      ram_op(32'h40, 1'b1, 1'b0, 32'h0, 4'h0);
      nvec++;
      if (bus.res.rd !== 32'hAA55CCDD) begin nerr++; $display("FAIL byte_store: got %h want aa55ccdd", bus.res.rd); end
   endtask

   // Back-to-back random RAM traffic over a small word set so RAW hits are frequent.
   task automatic test_random_ram();
      logic [31:0] a;
      int          k;
      int          op;
      for (int i = 0; i < 16; i++) ram_op({18'h0, 12'(i * 37), 2'b00}, 1'b0, 1'b1, $urandom, 4'hF);
      for (int i = 0; i < 80; i++) begin
         k  = $urandom_range(0, 15);
         op = $urandom_range(0, 3);
         a  = {18'h0, 12'(k * 37), 2'($urandom_range(0, 3))};
         case (op)
            0, 1:    ram_op(a, 1'b1, 1'b0, $urandom, 4'($urandom));
            2:       ram_op(a, 1'b0, 1'b1, $urandom, 4'($urandom_range(1, 15)));
            default: ram_op(a, 1'b1, 1'b1, $urandom, 4'($urandom_range(1, 15)));
         endcase
      end
   endtask

   task automatic test_io_read();
      io_txn(32'hB0000008, 1'b0, 32'h0, 4'h0, 3, 32'hCAFEF00D, '0);
      step();
      nvec++;
      if (bus.io_timeout !== 1'b0) begin nerr++; $display("FAIL io_read_no_timeout: got %b want 0", bus.io_timeout); end
      nvec++;
      if (bus.res.rd !== 32'hCAFEF00D) begin nerr++; $display("FAIL io_read_rd_held: got %h want cafef00d", bus.res.rd); end
   endtask

   task automatic test_random_io();
      logic [31:0] a;
      bit          wr;
      for (int i = 0; i < 10; i++) begin
         a  = {4'hB, 26'($urandom), 2'($urandom)};
         wr = 1'($urandom);
         io_txn(a, wr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom, '0);
         bus.req = '0;
         step();
      end
   endtask

   task automatic test_hold_request();
      int idx;
      ram_op(32'h80, 1'b0, 1'b1, 32'h01020304, 4'hF);
      ram_op(32'h84, 1'b0, 1'b1, 32'h0BADC0DE, 4'hF);
      io_txn(32'hB0000010, 1'b0, 32'h0, 4'h0, 2, 32'h13579BDF, mkreq(32'h80, 1'b0, 1'b1, 32'hA5A5A5A5, 4'h3));
      step();
      bus.req = '0;
      idx = int'(32'h80 >> 2);
      mem_m[idx] = merge(mem_m[idx], 32'hA5A5A5A5, 4'h3);
      ram_op(32'h80, 1'b1, 1'b0, 32'h0, 4'h0);
      nvec++;
      if (bus.res.rd !== 32'h0102A5A5) begin nerr++; $display("FAIL hold_write_once: got %h want 0102a5a5", bus.res.rd); end
      io_txn(32'hB0000014, 1'b0, 32'h0, 4'h0, 1, 32'h2468ACE0, mkreq(32'h84, 1'b1, 1'b0, 32'h0, 4'h0));
      step();
      bus.req = '0;
      nvec++;
      if (bus.res.rd !== 32'h0BADC0DE) begin nerr++; $display("FAIL hold_read_after_done: got %h want 0badc0de", bus.res.rd); end
   endtask

   task automatic test_back_to_back();
      io_txn(32'hB0000100, 1'b0, 32'h0, 4'h0, 0, 32'h76543210, mkreq(32'hB0000206, 1'b0, 1'b1, 32'h89ABCDEF, 4'h6));
      step();
      bus.req = '0;
      nvec++; if (bus.res.hold !== 1'b1)       begin nerr++; $display("FAIL b2b_hold: got %b want 1", bus.res.hold); end
      nvec++; if (bus.io_wr !== 1'b1 || bus.io_rd !== 1'b0) begin nerr++; $display("FAIL b2b_strobe: got rd=%b wr=%b want rd=0 wr=1", bus.io_rd, bus.io_wr); end
      nvec++; if (bus.io_addr !== 32'hB0000204) begin nerr++; $display("FAIL b2b_addr: got %h want b0000204", bus.io_addr); end
      nvec++; if (bus.io_wdata !== 32'h89ABCDEF) begin nerr++; $display("FAIL b2b_wdata: got %h want 89abcdef", bus.io_wdata); end
      nvec++; if (bus.io_be !== 4'h6)          begin nerr++; $display("FAIL b2b_be: got %h want 6", bus.io_be); end
      bus.io_ack = 1'b1;
      step();
      bus.io_ack = 1'b0;
      nvec++; if (bus.res.hold !== 1'b0 || bus.io_wr !== 1'b0) begin nerr++; $display("FAIL b2b_done: got hold=%b wr=%b want 0 0", bus.res.hold, bus.io_wr); end
      nvec++; if (bus.res.rd !== 32'h76543210) begin nerr++; $display("FAIL b2b_write_keeps_rd: got %h want 76543210", bus.res.rd); end
      step();
   endtask

   task automatic test_timeout();
      io_txn(32'hB0000040, 1'b1, 32'h12121212, 4'hF, -1, 32'h0, '0);
      step();
      nvec++;
      if (bus.io_timeout !== 1'b0 || bus.res.hold !== 1'b0) begin
         nerr++; $display("FAIL timeout_pulse_once: got to=%b hold=%b want 0 0", bus.io_timeout, bus.res.hold);
      end
      io_txn(32'hB0000044, 1'b0, 32'h0, 4'h0, -1, 32'h0, '0);
      step();
      io_txn(32'hB0000048, 1'b0, 32'h0, 4'h0, TMO - 1, 32'h600DF00D, '0);
      step();
   endtask

   task automatic test_async_reset();
      io_txn(32'hB0000020, 1'b0, 32'h0, 4'h0, 1, 32'h12345678, '0);
      step();
      bus.req = mkreq(32'hB0000030, 1'b1, 1'b0, 32'h0, 4'h0);
      step();
      bus.req = '0;
      step();
      nvec++;
      if (bus.res.hold !== 1'b1 || bus.io_rd !== 1'b1) begin nerr++; $display("FAIL arst_pre: got hold=%b rd=%b want 1 1", bus.res.hold, bus.io_rd); end
      #2;
      rst = 1'b1;
      #1;
      nvec++; if (bus.io_rd !== 1'b0)     begin nerr++; $display("FAIL arst_io_rd: got %b want 0", bus.io_rd); end
      nvec++; if (bus.res.hold !== 1'b0)  begin nerr++; $display("FAIL arst_hold: got %b want 0", bus.res.hold); end
      nvec++; if (bus.res.rd !== 32'h0)   begin nerr++; $display("FAIL arst_rd: got %h want 0", bus.res.rd); end
      step();
      rst = 1'b0;
      bus.io_ack = 1'b1;
      bus.io_rdata = 32'hFEEDFACE;
      step();
      bus.io_ack = 1'b0;
      nvec++;
      if (bus.res.hold !== 1'b0 || bus.io_rd !== 1'b0 || bus.res.rd !== 32'h0) begin
         nerr++; $display("FAIL arst_late_ack: got hold=%b rd=%b data=%h want 0 0 0", bus.res.hold, bus.io_rd, bus.res.rd);
      end
      ram_op(32'h40, 1'b1, 1'b0, 32'h0, 4'h0);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_store_load();
      test_byte_store();
      test_random_ram();
      test_io_read();
      test_random_io();
      test_hold_request();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the `REQ/`RES dmem interface; the slave end of the memory stage's initiator port.
- Services word/half/byte accesses to a local tightly-coupled RAM with one-cycle read latency.
- Forwards accesses in the I/O window to a simple handshaked peripheral bus.
- Asserts HOLD to stall the pipeline while a peripheral access is outstanding.

Parameters:
- ADDR_W, 12, log2 of RAM depth in 32-bit words (RAM indexed by A[ADDR_W+1:2]).
- IO_PREFIX, 4'hB, value of A[31:28] that selects the I/O window.
- IO_TIMEOUT, 255, cycles to wait for io_ack before aborting (8-bit counter).
- TIMEOUT_DATA, 32'hDEADBEEF, RD value returned for a timed-out I/O read.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- dmem_req  in  `REQ  request bundle: A[31:0], R, W, WD[31:0], WBE[3:0] (big-endian lanes: WBE[3]/WD[31:24] = byte offset 0).
- dmem_res  out  `RES  response bundle: RD[31:0], HOLD (combinational).
- io_addr  out  32  peripheral address, word-aligned copy of A.
- io_rd  out  1  peripheral read strobe, held until ack.
- io_wr  out  1  peripheral write strobe, held until ack.
- io_wdata  out  32  peripheral write data.
- io_be  out  4  peripheral byte enables.
- io_rdata  in  32  peripheral read data, valid with io_ack.
- io_ack  in  1  peripheral completion, one-cycle pulse.
- io_timeout  out  1  one-cycle pulse when an I/O access is aborted.

Behaviour:
- Reset (async, any state): state=IDLE; io_rd=io_wr=0; io_addr/io_wdata/io_be=0; HOLD=0; RD register=0; io_timeout=0; timeout counter=0. RAM contents are not reset.
- Acceptance: a request (R|W) is accepted at a rising edge only if HOLD=0 in that cycle. Requests presented while HOLD=1 are ignored; the pipeline holds the same request stable, so it is re-presented and accepted once HOLD drops. R and W both high: treated as W.
- RAM write, request in cycle N: at edge N, bytes with WBE[i]=1 are written. RD is don't-care in N+1.
- RAM read, request in cycle N: RD = word at A[ADDR_W+1:2] during N+1, HOLD=0. Lane extraction and sign extension are the requester's job; RD is always the full word.
- Read-after-write to the same word in consecutive cycles returns the new data. No bypass is needed because there is one request per cycle.
- FSM IDLE: an I/O request (A[31:28]==IO_PREFIX) accepted at edge N latches io_addr={A[31:2],2'b00}, io_wdata=WD, io_be=WBE (4'hF for reads), and raises io_rd or io_wr; next state is IO_WAIT. HOLD is asserted from cycle N+1.
- FSM IO_WAIT: HOLD=1; strobes held; counter increments.
  - io_ack sampled: drop strobes, latch io_rdata into the RD register, and go to IO_DONE.
  - Counter reaches IO_TIMEOUT first: drop strobes, load TIMEOUT_DATA, pulse io_timeout, and go to IO_DONE.
  - io_ack in the same cycle as the timeout: the ack wins.
- FSM IO_DONE (exactly one cycle): HOLD=0; RD = latched I/O data (reads); a new request may be accepted this cycle. Next state is IDLE, or IO_WAIT if the new request is I/O.
- RD mux: RAM output when the previous accepted access was a RAM read; otherwise the RD register.
- Write-ack, read data, and a late io_ack arriving in IDLE are ignored.
- Reset during IO_WAIT: strobes drop immediately and the outstanding access is discarded.

Decomposition:
- Shared header/package (pipeconnect.h): `REQ/`RES field macros, IO_PREFIX default, FSM state encodings (IDLE, IO_WAIT, IO_DONE).
- One sub-module, dmem_ram: single-port, synchronous-read, byte-enabled RAM (4 byte-wide lanes, optional init-file parameter).
- FSM, RD mux and timeout counter live in dmem_responder.

Test Plan:
- RAM store then load: W A=0x40 WD=0x11223344 WBE=F; next cycle R A=0x40 -> RD=0x11223344 in the following cycle, HOLD never high.
- Byte store: preload 0x40=0xAABBCCDD; W A=0x41 WD=0x55555555 WBE=4 -> read 0x40 gives RD=0xAA55CCDD.
- I/O read: R A=0xB0000008, io_ack with io_rdata=0xCAFEF00D three cycles after io_rd rises -> io_addr=0xB0000008, HOLD high for exactly the wait cycles, RD=0xCAFEF00D in the cycle HOLD drops.
- Request while HOLD: keep a RAM W to 0x80 presented during an I/O wait -> RAM at 0x80 is written exactly once, in the IO_DONE cycle.
- Timeout: I/O write, io_ack never arrives -> io_wr drops after IO_TIMEOUT cycles, io_timeout pulses once, HOLD releases; an I/O read timeout returns RD=0xDEADBEEF.
- Async reset during IO_WAIT: rst pulsed mid-cycle -> io_rd, HOLD and RD go to 0 without a clock edge; a subsequent io_ack is ignored and the next RAM read behaves normally.
